mem_fu_sched: RTL and testbench
===============================

# mem_fu_sched

Issue controller for the memory functional unit (FU_mem). Arbitrates round-robin between N_REQ reservation-station requesters, captures the winner's operands, drives the FU with a single-cycle enable, waits for its finish flag, then returns the result: load data is presented on the CDB with a valid/ack handshake, and store completion is signalled by a one-cycle done pulse. It sits between the memory reservation stations and FU_mem in the out-of-order core.

## Interface
- N_REQ, 2: number of requesters (≥2).
- TAG_W, 3: reservation-station tag width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request; held with its operands until granted.
- req_mem_w  in  N_REQ  1 = store, 0 = load.
- req_bhw  in  3*N_REQ  width/sign code, forwarded unchanged.
- req_rs1, req_rs2, req_imm  in  32*N_REQ each  base, store data, offset.
- req_tag  in  TAG_W*N_REQ  destination tag.
- gnt  out  N_REQ  one-hot, one-cycle grant pulse.
- fu_EN  out  1  FU enable, one-cycle pulse.
- fu_mem_w, fu_bhw, fu_rs1_data, fu_rs2_data, fu_imm  out  1/3/32/32/32  captured operands to FU.
- fu_finish  in  1  FU finish flag.
- fu_mem_data  in  32  FU read data, valid while fu_finish=1.
- cdb_valid  out  1  load result valid.
- cdb_tag  out  TAG_W;  cdb_data  out  32  load result.
- cdb_ack  in  1  CDB accepted the result.
- st_done  out  1  store-complete pulse;  st_tag  out  TAG_W.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESULT, SDONE.
- IDLE: if any req bit is set, pick the winner by round-robin starting at pointer `ptr`. On the clock edge, capture the winner's operands, mem_w, bhw, tag and index, then go to ISSUE. If no request, stay in IDLE.
- ISSUE (exactly 1 cycle): gnt[winner]=1, fu_EN=1, then go to WAIT. Update ptr to (winner+1) mod N_REQ.
- WAIT: fu_EN=0. When fu_finish=1:
  - load: latch fu_mem_data into cdb_data and go to RESULT.
  - store: go to SDONE.
- RESULT: cdb_valid=1 with cdb_tag and cdb_data stable until cdb_ack is sampled high, then go to IDLE. An ack in the first RESULT cycle is legal.
- SDONE (1 cycle): st_done=1, st_tag valid, then go to IDLE.
- fu_* operand outputs hold the captured values from ISSUE until the next capture.
- fu_finish is ignored outside WAIT.
- req bits are ignored outside IDLE. A requester deasserts req the cycle after gnt.
- Reset clears everything: state=IDLE, ptr=0, and every output (gnt, fu_EN, fu_* operands, cdb_*, st_*, busy) is 0. Reset mid-operation abandons the op. FU_mem has no reset, so a late fu_finish can arrive after reset and is ignored, because the controller is not in WAIT.

## Timing
- req first seen at edge of cycle 0 → gnt and fu_EN high in cycle 1.
- FU samples EN at end of cycle 1 → fu_finish high in cycle 3.
- Load: cdb_valid from cycle 4. Store: st_done in cycle 4.
- Minimum occupancy is 5 cycles per op (load with immediate ack). The next grant can be in cycle 6 at the earliest.
- No combinational path from req or cdb_ack to any output. Every output is registered or decoded from state.
- Simultaneous requests resolve by ptr; the same requester cannot win twice in a row while another is requesting.

## Structure
- Package mem_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESULT, SDONE);
  - TAG_W default;
  - BHW_W = 3.
- Sub-module rr_arbiter: combinational N_REQ-way round-robin pick from (req, ptr) → one-hot + index, with no state of its own. ptr lives in mem_fu_sched.

## Test plan
- Single load: req[0], rs1=0x100, imm=4, tag=5, RAM[0x104]=0xDEADBEEF → gnt[0] and fu_EN in cycle 1 only; cdb_valid in cycle 4 with tag 5, data 0xDEADBEEF.
- Single store: req[1], mem_w=1, rs2=0x12345678, tag=2 → st_done and st_tag=2 for one cycle in cycle 4, no cdb_valid. A following load from the same address returns 0x12345678.
- Contention: req=2'b11 held continuously, 6 ops total → grants alternate 0,1,0,1,0,1 starting with 0 after reset. fu_EN is never high while busy outside ISSUE.
- CDB back-pressure: load with cdb_ack held low for 7 cycles → cdb_valid, tag and data stable throughout. IDLE is reached the cycle after ack, and a waiting req[1] is granted one cycle after that.
- Reset mid-WAIT: rst asserted in cycle 2 → all outputs 0 immediately and busy=0. The stray fu_finish in cycle 3 produces no cdb_valid or st_done.
- Stray finish: force fu_finish=1 while in IDLE → no state change and no outputs.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and constants for the memory FU issue controller
package mem_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESULT,
        SDONE
    } state_t;

    localparam int TAG_W_DEF = 3;
    localparam int BHW_W     = 3;

    // Slot visited at position 'offset' of a round-robin scan that starts at 'base'.
    function automatic int rr_slot(int base, int offset, int n);
        int s;
        s = base + offset;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_fu_sched_if.sv
// rtl/mem_fu_sched_if.sv - requester, FU and CDB signals of the memory FU issue controller
interface mem_fu_sched_if
    import mem_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = TAG_W_DEF
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_mem_w;
    logic [BHW_W*N_REQ-1:0] req_bhw;
    logic [32*N_REQ-1:0]    req_rs1;
    logic [32*N_REQ-1:0]    req_rs2;
    logic [32*N_REQ-1:0]    req_imm;
    logic [TAG_W*N_REQ-1:0] req_tag;
    logic [N_REQ-1:0]       gnt;

    logic                   fu_EN;
    logic                   fu_mem_w;
    logic [BHW_W-1:0]       fu_bhw;
    logic [31:0]            fu_rs1_data;
    logic [31:0]            fu_rs2_data;
    logic [31:0]            fu_imm;
    logic                   fu_finish;
    logic [31:0]            fu_mem_data;

    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [31:0]            cdb_data;
    logic                   cdb_ack;

    logic                   st_done;
    logic [TAG_W-1:0]       st_tag;
    logic                   busy;

    modport master (
        input  req, req_mem_w, req_bhw, req_rs1, req_rs2, req_imm, req_tag,
        input  fu_finish, fu_mem_data, cdb_ack,
        output gnt, fu_EN, fu_mem_w, fu_bhw, fu_rs1_data, fu_rs2_data, fu_imm,
        output cdb_valid, cdb_tag, cdb_data, st_done, st_tag, busy
    );

    modport slave (
        output req, req_mem_w, req_bhw, req_rs1, req_rs2, req_imm, req_tag,
        output fu_finish, fu_mem_data, cdb_ack,
        input  gnt, fu_EN, fu_mem_w, fu_bhw, fu_rs1_data, fu_rs2_data, fu_imm,
        input  cdb_valid, cdb_tag, cdb_data, st_done, st_tag, busy
    );

endinterface

// File: rtl/mem_fu_sched_rr_arbiter.sv
// rtl/mem_fu_sched_rr_arbiter.sv - stateless round-robin pick starting at a given pointer
module rr_arbiter
    import mem_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] slot;

    // Scan from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        slot   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            slot = IDX_W'(rr_slot(int'(ptr), k, N_REQ));
            if (req[slot]) begin
                idx   = slot;
                valid = 1'b1;
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_fu_sched.sv
// rtl/mem_fu_sched.sv - issue controller: round-robin grant, FU enable, load result on CDB, store done pulse
module mem_fu_sched
    import mem_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_fu_sched_if.master bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] ptr_next;
    logic [TAG_W-1:0] cap_tag;

    logic [N_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    logic             op_mem_w [N_REQ];
    logic [BHW_W-1:0] op_bhw   [N_REQ];
    logic [31:0]      op_rs1   [N_REQ];
    logic [31:0]      op_rs2   [N_REQ];
    logic [31:0]      op_imm   [N_REQ];
    logic [TAG_W-1:0] op_tag   [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_mem_w[i] = bus.req_mem_w[i];
        assign op_bhw[i]   = bus.req_bhw[i*BHW_W +: BHW_W];
        assign op_rs1[i]   = bus.req_rs1[i*32 +: 32];
        assign op_rs2[i]   = bus.req_rs2[i*32 +: 32];
        assign op_imm[i]   = bus.req_imm[i*32 +: 32];
        assign op_tag[i]   = bus.req_tag[i*TAG_W +: TAG_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    always_comb begin
        ptr_next = '0;
        if (win_idx != IDX_W'(N_REQ - 1)) begin
            ptr_next = win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            win_idx         <= '0;
            cap_tag         <= '0;
            bus.gnt         <= '0;
            bus.fu_EN       <= 1'b0;
            bus.fu_mem_w    <= 1'b0;
            bus.fu_bhw      <= '0;
            bus.fu_rs1_data <= '0;
            bus.fu_rs2_data <= '0;
            bus.fu_imm      <= '0;
            bus.cdb_valid   <= 1'b0;
            bus.cdb_tag     <= '0;
            bus.cdb_data    <= '0;
            bus.st_done     <= 1'b0;
            bus.st_tag      <= '0;
            bus.busy        <= 1'b0;
        end else begin
            bus.gnt     <= '0;
            bus.fu_EN   <= 1'b0;
            bus.st_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        win_idx         <= arb_idx;
                        cap_tag         <= op_tag[arb_idx];
                        bus.fu_mem_w    <= op_mem_w[arb_idx];
                        bus.fu_bhw      <= op_bhw[arb_idx];
                        bus.fu_rs1_data <= op_rs1[arb_idx];
                        bus.fu_rs2_data <= op_rs2[arb_idx];
                        bus.fu_imm      <= op_imm[arb_idx];
                        bus.gnt         <= arb_onehot;
                        bus.fu_EN       <= 1'b1;
                        bus.busy        <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr   <= ptr_next;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.fu_finish) begin
                        if (bus.fu_mem_w) begin
                            bus.st_done <= 1'b1;
                            bus.st_tag  <= cap_tag;
                            state       <= SDONE;
                        end else begin
                            bus.cdb_valid <= 1'b1;
                            bus.cdb_tag   <= cap_tag;
                            bus.cdb_data  <= bus.fu_mem_data;
                            state         <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (bus.cdb_ack) begin
                        bus.cdb_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                SDONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.cdb_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fu_sched.sv
// tb/tb_mem_fu_sched.sv - scoreboard bench for mem_fu_sched with a behavioural FU/RAM model
module tb_mem_fu_sched;
    import mem_sched_pkg::*;

    localparam int N  = 2;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_fu_sched_if #(.N_REQ(N), .TAG_W(TW)) bus ();
    mem_fu_sched #(.N_REQ(N), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic fin_model = 1'b0;
    logic fin_stray = 1'b0;
    assign bus.fu_finish = fin_model | fin_stray;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          st;
        logic [TW-1:0] tag;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] ram       [logic [31:0]];
    int          mptr = 0;
    int          fu_extra_max = 0;

    logic          op_w   [N];
    logic [2:0]    op_bhw [N];
    logic [31:0]   op_rs1 [N];
    logic [31:0]   op_rs2 [N];
    logic [31:0]   op_imm [N];
    logic [TW-1:0] op_tag [N];

    logic [N-1:0] prev_req = '0;
    logic [N-1:0] last_gnt = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(logic [31:0] a);
        return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] model_rd(logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ram_rd(logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    task automatic set_op(int i, logic w, logic [2:0] bhw, logic [31:0] rs1, logic [31:0] rs2,
                          logic [31:0] imm, logic [TW-1:0] tag);
        op_w[i] = w; op_bhw[i] = bhw; op_rs1[i] = rs1; op_rs2[i] = rs2; op_imm[i] = imm; op_tag[i] = tag;
        bus.req_mem_w[i]          = w;
        bus.req_bhw[i*3 +: 3]     = bhw;
        bus.req_rs1[i*32 +: 32]   = rs1;
        bus.req_rs2[i*32 +: 32]   = rs2;
        bus.req_imm[i*32 +: 32]   = imm;
        bus.req_tag[i*TW +: TW]   = tag;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while ((bus.busy || sb.size() != 0) && n < 100) begin
            adv();
            mid();
            n++;
        end
        chk(nm, 32'(n < 100), 32'd1);
    endtask

    // FU_mem model: EN seen in cycle k gives finish in cycle k+2 (+ optional extra latency); no reset.
    initial begin
        logic [31:0] a, d;
        logic        w;
        int          lat;
        bus.fu_mem_data = '0;
        forever begin
            @(negedge clk);
            if (bus.fu_EN && !rst) begin
                a   = bus.fu_rs1_data + bus.fu_imm;
                d   = bus.fu_rs2_data;
                w   = bus.fu_mem_w;
                lat = (fu_extra_max > 0) ? $urandom_range(0, fu_extra_max) : 0;
                @(posedge clk);
                @(posedge clk);
                repeat (lat) @(posedge clk);
                #1;
                if (w) ram[a] = d;
                else   bus.fu_mem_data = ram_rd(a);
                fin_model = 1'b1;
                @(posedge clk);
                #1;
                fin_model = 1'b0;
            end
        end
    end

    // Monitor: predicts the grant from the requests seen in the idle cycle, queues the expected result.
    initial begin
        exp_t          e;
        int            w;
        logic [31:0]   a;
        logic [N-1:0]  eg;
        bit            cdb_hold = 0;
        logic [TW-1:0] hold_tag = '0;
        logic [31:0]   hold_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                mptr = 0;
                cdb_hold = 0;
                prev_req = '0;
                last_gnt = '0;
            end else begin
                if (bus.gnt != '0 || bus.fu_EN) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && prev_req[(mptr + k) % N]) w = (mptr + k) % N;
                    eg = (w < 0) ? '0 : N'(1 << w);
                    chk("gnt", 32'(bus.gnt), 32'(eg));
                    chk("fu_en_with_gnt", 32'(bus.fu_EN), 32'd1);
                    if (w >= 0) begin
                        chk("fu_mem_w", 32'(bus.fu_mem_w), 32'(op_w[w]));
                        chk("fu_bhw", 32'(bus.fu_bhw), 32'(op_bhw[w]));
                        chk("fu_rs1", bus.fu_rs1_data, op_rs1[w]);
                        chk("fu_rs2", bus.fu_rs2_data, op_rs2[w]);
                        chk("fu_imm", bus.fu_imm, op_imm[w]);
                        mptr = (w + 1) % N;
                        a = op_rs1[w] + op_imm[w];
                        e.st = op_w[w];
                        e.tag = op_tag[w];
                        if (op_w[w]) begin
                            model_mem[a] = op_rs2[w];
                            e.data = '0;
                        end else begin
                            e.data = model_rd(a);
                        end
                        sb.push_back(e);
                    end
                end
                if (bus.cdb_valid) begin
                    if (!cdb_hold) begin
                        if (sb.size() == 0) begin
                            chk("cdb_unexpected", 32'(bus.cdb_valid), 32'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("cdb_for_store", 32'(e.st), 32'd0);
                            chk("cdb_tag", 32'(bus.cdb_tag), 32'(e.tag));
                            chk("cdb_data", bus.cdb_data, e.data);
                            hold_tag = e.tag;
                            hold_data = e.data;
                            cdb_hold = 1;
                        end
                    end else begin
                        chk("cdb_tag_stable", 32'(bus.cdb_tag), 32'(hold_tag));
                        chk("cdb_data_stable", bus.cdb_data, hold_data);
                    end
                    if (bus.cdb_ack) cdb_hold = 0;
                end else if (cdb_hold) begin
                    chk("cdb_dropped", 32'(bus.cdb_valid), 32'd1);
                    cdb_hold = 0;
                end
                if (bus.st_done) begin
                    if (sb.size() == 0) begin
                        chk("st_unexpected", 32'(bus.st_done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("st_for_load", 32'(e.st), 32'd1);
                        chk("st_tag", 32'(bus.st_tag), 32'(e.tag));
                        chk("st_no_cdb", 32'(bus.cdb_valid), 32'd0);
                    end
                end
                prev_req = bus.req;
                last_gnt = bus.gnt;
            end
        end
    end

    initial begin
        int n;
        int order[$];
        bus.req = '0; bus.req_mem_w = '0; bus.req_bhw = '0; bus.req_rs1 = '0;
        bus.req_rs2 = '0; bus.req_imm = '0; bus.req_tag = '0; bus.cdb_ack = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 0, 0, 0, 0, 0, 0);

        repeat (2) mid();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_en", 32'(bus.fu_EN), 0);
        chk("rst_cdb_valid", 32'(bus.cdb_valid), 0);
        chk("rst_st_done", 32'(bus.st_done), 0);
        chk("rst_fu_rs1", bus.fu_rs1_data, 0);
        adv(); rst = 1'b0;

        // single load
        ram[32'h104] = 32'hDEADBEEF; model_mem[32'h104] = 32'hDEADBEEF;
        adv(); set_op(0, 0, 3'b010, 32'h100, 32'h0, 32'h4, 3'd5); bus.req = 2'b01; mid();
        chk("ld_c0_gnt", 32'(bus.gnt), 0);
        adv(); mid();
        chk("ld_c1_gnt", 32'(bus.gnt), 32'b01);
        chk("ld_c1_en", 32'(bus.fu_EN), 1);
        adv(); bus.req = '0; mid();
        chk("ld_c2_gnt", 32'(bus.gnt), 0);
        chk("ld_c2_en", 32'(bus.fu_EN), 0);
        chk("ld_c2_busy", 32'(bus.busy), 1);
        adv(); mid();
        chk("ld_c3_valid", 32'(bus.cdb_valid), 0);
        adv(); mid();
        chk("ld_c4_valid", 32'(bus.cdb_valid), 1);
        chk("ld_c4_tag", 32'(bus.cdb_tag), 5);
        chk("ld_c4_data", bus.cdb_data, 32'hDEADBEEF);
        adv(); mid();
        chk("ld_c5_valid", 32'(bus.cdb_valid), 0);
        chk("ld_c5_busy", 32'(bus.busy), 0);

        // single store, then load back
        adv(); set_op(1, 1, 3'b010, 32'h200, 32'h12345678, 32'h8, 3'd2); bus.req = 2'b10; mid();
        adv(); mid();
        chk("st_c1_gnt", 32'(bus.gnt), 32'b10);
        adv(); bus.req = '0; mid();
        adv(); mid();
        chk("st_c3_done", 32'(bus.st_done), 0);
        adv(); mid();
        chk("st_c4_done", 32'(bus.st_done), 1);
        chk("st_c4_tag", 32'(bus.st_tag), 2);
        chk("st_c4_novalid", 32'(bus.cdb_valid), 0);
        adv(); mid();
        chk("st_c5_done", 32'(bus.st_done), 0);
        adv(); set_op(0, 0, 3'b010, 32'h200, 32'h0, 32'h8, 3'd3); bus.req = 2'b01; mid();
        adv(); mid();
        adv(); bus.req = '0; mid();
        n = 0;
        while (!bus.cdb_valid && n < 10) begin adv(); mid(); n++; end
        chk("ldback_timeout", 32'(n < 10), 1);
        chk("ldback_data", bus.cdb_data, 32'h12345678);
        wait_idle("ldback_idle");

        // contention after reset
        adv(); rst = 1'b1; mid();
        adv(); rst = 1'b0;
        set_op(0, 0, 3'b000, 32'h110, 32'h0, 32'h0, 3'd1);
        set_op(1, 0, 3'b001, 32'h114, 32'h0, 32'h0, 3'd4);
        bus.req = 2'b11; mid();
        for (int c = 0; c < 80 && order.size() < 6; c++) begin
            adv(); mid();
            if (bus.gnt == 2'b01) order.push_back(0);
            if (bus.gnt == 2'b10) order.push_back(1);
            if (bus.fu_EN) chk("cont_en_only_issue", 32'(bus.gnt != '0), 1);
        end
        adv(); bus.req = '0; mid();
        chk("cont_count", order.size(), 6);
        for (int i = 0; i < order.size(); i++) chk($sformatf("cont_order%0d", i), order[i], i % 2);
        wait_idle("cont_idle");

        // CDB back-pressure with requester 1 waiting
        ram[32'h120] = 32'hCAFEF00D; model_mem[32'h120] = 32'hCAFEF00D;
        adv(); bus.cdb_ack = 1'b0; set_op(0, 0, 3'b100, 32'h120, 32'h0, 32'h0, 3'd6); bus.req = 2'b01; mid();
        adv(); mid();
        chk("bp_c1_gnt", 32'(bus.gnt), 32'b01);
        adv(); set_op(1, 0, 3'b010, 32'h124, 32'h0, 32'h0, 3'd7); bus.req = 2'b10; mid();
        adv(); mid();
        for (int c = 4; c <= 10; c++) begin
            adv(); mid();
            chk($sformatf("bp_c%0d_valid", c), 32'(bus.cdb_valid), 1);
            chk($sformatf("bp_c%0d_tag", c), 32'(bus.cdb_tag), 6);
            chk($sformatf("bp_c%0d_data", c), bus.cdb_data, 32'hCAFEF00D);
        end
        adv(); bus.cdb_ack = 1'b1; mid();
        chk("bp_c11_valid", 32'(bus.cdb_valid), 1);
        adv(); mid();
        chk("bp_c12_busy", 32'(bus.busy), 0);
        chk("bp_c12_valid", 32'(bus.cdb_valid), 0);
        chk("bp_c12_gnt", 32'(bus.gnt), 0);
        adv(); mid();
        chk("bp_c13_gnt", 32'(bus.gnt), 32'b10);
        adv(); bus.req = '0; mid();
        wait_idle("bp_idle");

        // reset while waiting on the FU
        adv(); set_op(0, 0, 3'b010, 32'h130, 32'h0, 32'h0, 3'd1); bus.req = 2'b01; mid();
        adv(); mid();
        chk("rw_c1_gnt", 32'(bus.gnt), 32'b01);
        adv(); bus.req = '0; rst = 1'b1; mid();
        chk("rw_busy", 32'(bus.busy), 0);
        chk("rw_gnt", 32'(bus.gnt), 0);
        chk("rw_en", 32'(bus.fu_EN), 0);
        chk("rw_fu_rs1", bus.fu_rs1_data, 0);
        chk("rw_cdb_data", bus.cdb_data, 0);
        adv(); rst = 1'b0; mid();
        for (int c = 3; c <= 6; c++) begin
            chk($sformatf("rw_c%0d_valid", c), 32'(bus.cdb_valid), 0);
            chk($sformatf("rw_c%0d_st", c), 32'(bus.st_done), 0);
            chk($sformatf("rw_c%0d_busy", c), 32'(bus.busy), 0);
            adv(); mid();
        end

        // stray finish while idle
        adv(); fin_stray = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("stray_busy", 32'(bus.busy), 0);
            chk("stray_valid", 32'(bus.cdb_valid), 0);
            chk("stray_st", 32'(bus.st_done), 0);
            chk("stray_en", 32'(bus.fu_EN), 0);
            adv();
        end
        fin_stray = 1'b0;
        mid();

        // randomized traffic with random FU latency and CDB back-pressure
        fu_extra_max = 3;
        for (int c = 0; c < 1500; c++) begin
            adv();
            bus.cdb_ack = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                if (last_gnt[i]) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    set_op(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                           32'h100 + 32'(16 * $urandom_range(0, 3)), $urandom,
                           32'(4 * $urandom_range(0, 3)), TW'($urandom_range(0, 7)));
                    bus.req[i] = 1'b1;
                end
            end
            mid();
        end
        adv(); bus.req = '0; bus.cdb_ack = 1'b1; mid();
        wait_idle("drain_idle");
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
